// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes, arbiter
// state encoding and default datapath widths.
package alu_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int CTRL_W_DEFAULT = 3;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // OWNx: requester x holds a lock on the ALU
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arb_rr.sv
// Combinational grant logic: lock ownership first, then round-robin
// between the two requesters when both are valid.
module alu_arb_rr
    import alu_pkg::*;
(
    input  arb_state_e state,
    input  logic       rr_ptr,
    input  logic       valid0,
    input  logic       valid1,
    output logic       grant0,
    output logic       grant1
);

    // rr_ptr names the last winner, so a tie goes to the other requester
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            OWN0:    grant0 = valid0;
            OWN1:    grant1 = valid1;
            default: begin
                if (valid0 && valid1) begin
                    grant0 = rr_ptr;
                    grant1 = !rr_ptr;
                end else begin
                    grant0 = valid0;
                    grant1 = valid1;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for the shared single-cycle ALU with a two-stage
// operand/result pipeline. Define ALU_ARB_PERF_EN to enable stall counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_lock,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [DATA_W-1:0] req0_in1,
    input  logic [DATA_W-1:0] req0_in2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_lock,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [DATA_W-1:0] req1_in1,
    input  logic [DATA_W-1:0] req1_in2,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic [15:0]       perf_wait0,
    output logic [15:0]       perf_wait1
);

    arb_state_e        state_q, state_d;
    logic              rr_q, rr_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_owner_q, s1_owner_d;
    logic [DATA_W-1:0] resp_result_q, resp_result_d;
    logic              resp_zero_q, resp_zero_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic              grant0, grant1;
    logic              hs0, hs1;

    alu_arb_rr u_rr (
        .state  (state_q),
        .rr_ptr (rr_q),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign hs0 = req0_valid && grant0;
    assign hs1 = req1_valid && grant1;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        alu_ctrl_d    = alu_ctrl_q;
        alu_in1_d     = alu_in1_q;
        alu_in2_d     = alu_in2_q;
        s1_valid_d    = 1'b0;
        s1_owner_d    = s1_owner_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        resp0_valid_d = s1_valid_q && !s1_owner_q;
        resp1_valid_d = s1_valid_q && s1_owner_q;

        if (hs0) begin
            state_d    = req0_lock ? OWN0 : IDLE;
            rr_d       = 1'b0;
            alu_ctrl_d = req0_ctrl;
            alu_in1_d  = req0_in1;
            alu_in2_d  = req0_in2;
            s1_valid_d = 1'b1;
            s1_owner_d = 1'b0;
        end else if (hs1) begin
            state_d    = req1_lock ? OWN1 : IDLE;
            rr_d       = 1'b1;
            alu_ctrl_d = req1_ctrl;
            alu_in1_d  = req1_in1;
            alu_in2_d  = req1_in2;
            s1_valid_d = 1'b1;
            s1_owner_d = 1'b1;
        end

        // Result bus only moves when an op leaves stage 1
        if (s1_valid_q) begin
            resp_result_d = alu_result;
            resp_zero_d   = alu_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_q          <= 1'b1;
            alu_ctrl_q    <= '0;
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
            s1_valid_q    <= 1'b0;
            s1_owner_q    <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            alu_ctrl_q    <= alu_ctrl_d;
            alu_in1_q     <= alu_in1_d;
            alu_in2_q     <= alu_in2_d;
            s1_valid_q    <= s1_valid_d;
            s1_owner_q    <= s1_owner_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign alu_ctrl    = alu_ctrl_q;
    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] perf_wait0_q, perf_wait0_d;
    logic [15:0] perf_wait1_q, perf_wait1_d;

    // Saturating counts of cycles a requester was valid but not accepted
    always_comb begin
        perf_wait0_d = perf_wait0_q;
        perf_wait1_d = perf_wait1_q;
        if (req0_valid && !grant0 && (perf_wait0_q != 16'hFFFF))
            perf_wait0_d = perf_wait0_q + 16'd1;
        if (req1_valid && !grant1 && (perf_wait1_q != 16'hFFFF))
            perf_wait1_d = perf_wait1_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_wait0_q <= '0;
            perf_wait1_q <= '0;
        end else begin
            perf_wait0_q <= perf_wait0_d;
            perf_wait1_q <= perf_wait1_d;
        end
    end

    assign perf_wait0 = perf_wait0_q;
    assign perf_wait1 = perf_wait1_q;
`else
    assign perf_wait0 = '0;
    assign perf_wait1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// reset/stall sequences and randomized traffic against a queue-based model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req0_lock;
    logic [2:0]  req0_ctrl;
    logic [31:0] req0_in1, req0_in2;
    logic        req1_valid, req1_ready, req1_lock;
    logic [2:0]  req1_ctrl;
    logic [31:0] req1_in1, req1_in2;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic        alu_zero;
    logic        resp0_valid, resp1_valid;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [15:0] perf_wait0, perf_wait1;

    int tests_run = 0;
    int tests_failed = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
        .req0_ctrl(req0_ctrl), .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
        .req1_ctrl(req1_ctrl), .req1_in1(req1_in1), .req1_in2(req1_in2),
        .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .perf_wait0(perf_wait0), .perf_wait1(perf_wait1)
    );

    always #5 clk = ~clk;

    // The ALU itself: plain arithmetic on the decoded control code
    function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_ctrl, alu_in1, alu_in2);
    assign alu_zero = (alu_result == 32'd0);

    typedef struct packed {
        logic        rst;
        logic        v0;
        logic        l0;
        logic [2:0]  c0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        v1;
        logic        l1;
        logic [2:0]  c1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        er0;
        logic        er1;
        logic        ev0;
        logic        ev1;
        logic [31:0] eres;
        logic        ez;
    } vec_t;

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic        z;
        int          due;
    } resp_t;

    // Reference model: lock owner (-1 none), last winner, pending responses
    int          m_owner;
    int          m_last;
    resp_t       m_q[$];
    logic [2:0]  m_ctrl;
    logic [31:0] m_in1, m_in2;
    int          m_perf0, m_perf1;
    int          edge_cnt = 0;

    logic        obs_r0, obs_r1, obs_v0, obs_v1, obs_z;
    logic [31:0] obs_res;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int expPerf(input int cnt);
`ifdef ALU_ARB_PERF_EN
        return cnt;
`else
        return 0 * cnt;
`endif
    endfunction

    task automatic driveIdle();
        req0_valid = 0; req0_lock = 0; req0_ctrl = 0; req0_in1 = 0; req0_in2 = 0;
        req1_valid = 0; req1_lock = 0; req1_ctrl = 0; req1_in1 = 0; req1_in2 = 0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " req0_ready"}, 32'(req0_ready), 0);
        checkOutput({tag, " req1_ready"}, 32'(req1_ready), 0);
        checkOutput({tag, " resp0_valid"}, 32'(resp0_valid), 0);
        checkOutput({tag, " resp1_valid"}, 32'(resp1_valid), 0);
        checkOutput({tag, " alu_ctrl"}, 32'(alu_ctrl), 0);
        checkOutput({tag, " alu_in1"}, alu_in1, 0);
        checkOutput({tag, " alu_in2"}, alu_in2, 0);
        checkOutput({tag, " resp_result"}, resp_result, 0);
        checkOutput({tag, " resp_zero"}, 32'(resp_zero), 0);
        checkOutput({tag, " perf_wait0"}, 32'(perf_wait0), 0);
        checkOutput({tag, " perf_wait1"}, 32'(perf_wait1), 0);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        driveIdle();
        rst_n = 1'b0;
        m_owner = -1; m_last = 1; m_q.delete();
        m_ctrl = 0; m_in1 = 0; m_in2 = 0; m_perf0 = 0; m_perf1 = 0;
        #1 checkReset({tag, " asserted"});
        @(negedge clk);
        checkReset({tag, " held"});
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, check grants, model the edge, check outputs
    task automatic applyStimulus(input vec_t v);
        bit    g0, g1;
        resp_t r;
        bit    ev0, ev1;
        if (v.rst) doReset("table reset");
        @(negedge clk);
        req0_valid = v.v0; req0_lock = v.l0; req0_ctrl = v.c0; req0_in1 = v.a0; req0_in2 = v.b0;
        req1_valid = v.v1; req1_lock = v.l1; req1_ctrl = v.c1; req1_in1 = v.a1; req1_in2 = v.b1;
        #1;
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        if (m_owner == 0) begin
            g0 = v.v0; g1 = 0;
        end else if (m_owner == 1) begin
            g0 = 0; g1 = v.v1;
        end else if (v.v0 && v.v1) begin
            g0 = (m_last == 1); g1 = !g0;
        end else begin
            g0 = v.v0; g1 = v.v1;
        end
        checkOutput("model req0_ready", 32'(obs_r0), 32'(g0));
        checkOutput("model req1_ready", 32'(obs_r1), 32'(g1));
        if (v.v0 && !g0 && m_perf0 < 65535) m_perf0++;
        if (v.v1 && !g1 && m_perf1 < 65535) m_perf1++;
        if (g0 || g1) begin
            r.owner = g0 ? 0 : 1;
            m_ctrl  = g0 ? v.c0 : v.c1;
            m_in1   = g0 ? v.a0 : v.a1;
            m_in2   = g0 ? v.b0 : v.b1;
            r.res   = alu_fn(m_ctrl, m_in1, m_in2);
            r.z     = (r.res == 0);
            r.due   = edge_cnt + 2;
            m_q.push_back(r);
            m_last  = r.owner;
            m_owner = (g0 ? v.l0 : v.l1) ? r.owner : -1;
        end
        @(posedge clk);
        #1;
        edge_cnt++;
        obs_v0 = resp0_valid; obs_v1 = resp1_valid; obs_res = resp_result; obs_z = resp_zero;
        ev0 = 0; ev1 = 0;
        if (m_q.size() > 0 && m_q[0].due == edge_cnt) begin
            r = m_q.pop_front();
            ev0 = (r.owner == 0);
            ev1 = (r.owner == 1);
            checkOutput("model resp_result", obs_res, r.res);
            checkOutput("model resp_zero", 32'(obs_z), 32'(r.z));
        end
        checkOutput("model resp0_valid", 32'(obs_v0), 32'(ev0));
        checkOutput("model resp1_valid", 32'(obs_v1), 32'(ev1));
        checkOutput("model alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        checkOutput("model alu_in1", alu_in1, m_in1);
        checkOutput("model alu_in2", alu_in2, m_in2);
        checkOutput("model perf_wait0", 32'(perf_wait0), expPerf(m_perf0));
        checkOutput("model perf_wait1", 32'(perf_wait1), expPerf(m_perf1));
    endtask

    function automatic vec_t mk(input logic rst,
                                input logic v0, input logic l0, input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic v1, input logic l1, input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic er0, input logic er1, input logic ev0, input logic ev1,
                                input logic [31:0] eres, input logic ez);
        vec_t v;
        v = '{rst, v0, l0, c0, a0, b0, v1, l1, c1, a1, b1, er0, er1, ev0, ev1, eres, ez};
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t r;
        logic [2:0] codes[6];
        codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, 3'b011};
        driveIdle();

        // Single op
        tbl.push_back(mk(1, 1,0,ALU_ADD,5,7,  0,0,0,0,0,       1,0, 0,0, 0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,        0,0,0,0,0,       0,0, 1,0, 12,0));
        tbl.push_back(mk(0, 0,0,0,0,0,        0,0,0,0,0,       0,0, 0,0, 0,0));
        // Tie from reset: req0 first, then alternate
        tbl.push_back(mk(1, 1,0,ALU_SUB,9,9,  1,0,ALU_OR,1,2,  1,0, 0,0, 0,0));
        tbl.push_back(mk(0, 1,0,ALU_SUB,9,9,  1,0,ALU_OR,1,2,  0,1, 1,0, 0,1));
        tbl.push_back(mk(0, 1,0,ALU_SUB,9,9,  1,0,ALU_OR,1,2,  1,0, 0,1, 3,0));
        tbl.push_back(mk(0, 1,0,ALU_SUB,9,9,  1,0,ALU_OR,1,2,  0,1, 1,0, 0,1));
        tbl.push_back(mk(0, 0,0,0,0,0,        0,0,0,0,0,       0,0, 0,1, 3,0));
        tbl.push_back(mk(0, 0,0,0,0,0,        0,0,0,0,0,       0,0, 0,0, 0,0));
        // Lock held by req1 for three ops while req0 waits
        tbl.push_back(mk(0, 1,0,ALU_ADD,1,1,  0,0,0,0,0,              1,0, 0,0, 0,0));
        tbl.push_back(mk(0, 1,0,ALU_ADD,1,1,  1,1,ALU_SLT,3,4,        0,1, 1,0, 2,0));
        tbl.push_back(mk(0, 1,0,ALU_ADD,1,1,  1,1,ALU_AND,32'hF0,32'h0F, 0,1, 0,1, 1,0));
        tbl.push_back(mk(0, 1,0,ALU_ADD,1,1,  1,0,ALU_ADD,10,20,      0,1, 0,1, 0,1));
        tbl.push_back(mk(0, 1,0,ALU_ADD,1,1,  0,0,0,0,0,              1,0, 0,1, 30,0));
        tbl.push_back(mk(0, 0,0,0,0,0,        0,0,0,0,0,              0,0, 1,0, 2,0));
        tbl.push_back(mk(0, 0,0,0,0,0,        0,0,0,0,0,              0,0, 0,0, 0,0));
        // Undefined control code
        tbl.push_back(mk(0, 1,0,3'b011,5,6,   0,0,0,0,0,       1,0, 0,0, 0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,        0,0,0,0,0,       0,0, 1,0, 0,1));
        tbl.push_back(mk(0, 0,0,0,0,0,        0,0,0,0,0,       0,0, 0,0, 0,0));
        // Lock and valid drop together: req1 stays blocked until req0 unlocks
        tbl.push_back(mk(0, 1,1,ALU_AND,1,1,  0,0,0,0,0,       1,0, 0,0, 0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,        1,0,ALU_OR,1,1,  0,0, 1,0, 1,0));
        tbl.push_back(mk(0, 0,0,0,0,0,        1,0,ALU_OR,1,1,  0,0, 0,0, 0,0));
        tbl.push_back(mk(0, 1,0,ALU_OR,0,0,   1,0,ALU_OR,1,1,  1,0, 0,0, 0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,        1,0,ALU_OR,1,1,  0,1, 1,0, 0,1));
        tbl.push_back(mk(0, 0,0,0,0,0,        0,0,0,0,0,       0,0, 0,1, 1,0));
        tbl.push_back(mk(0, 0,0,0,0,0,        0,0,0,0,0,       0,0, 0,0, 0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d req0_ready", i), 32'(obs_r0), 32'(tbl[i].er0));
            checkOutput($sformatf("vec%0d req1_ready", i), 32'(obs_r1), 32'(tbl[i].er1));
            checkOutput($sformatf("vec%0d resp0_valid", i), 32'(obs_v0), 32'(tbl[i].ev0));
            checkOutput($sformatf("vec%0d resp1_valid", i), 32'(obs_v1), 32'(tbl[i].ev1));
            if (tbl[i].ev0 || tbl[i].ev1) begin
                checkOutput($sformatf("vec%0d resp_result", i), obs_res, tbl[i].eres);
                checkOutput($sformatf("vec%0d resp_zero", i), 32'(obs_z), 32'(tbl[i].ez));
            end
        end

        // Reset one cycle after acceptance discards the in-flight op
        applyStimulus(mk(0, 1,0,ALU_ADD,5,7, 0,0,0,0,0, 0,0,0,0,0,0));
        checkOutput("midreset accepted", 32'(obs_r0), 1);
        doReset("midreset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus('0);
            checkOutput("midreset resp0_valid", 32'(obs_v0), 0);
            checkOutput("midreset resp1_valid", 32'(obs_v1), 0);
        end

        // req1 blocked for five cycles by req0's lock
        doReset("perf");
        for (int i = 0; i < 4; i++)
            applyStimulus(mk(0, 1,1,ALU_ADD,i,1, 1,0,ALU_OR,2,2, 0,0,0,0,0,0));
        applyStimulus(mk(0, 1,0,ALU_ADD,7,1, 1,0,ALU_OR,2,2, 0,0,0,0,0,0));
        applyStimulus(mk(0, 0,0,0,0,0,       1,0,ALU_OR,2,2, 0,0,0,0,0,0));
        checkOutput("perf req1 granted", 32'(obs_r1), 1);
        applyStimulus('0);
`ifdef ALU_ARB_PERF_EN
        checkOutput("perf_wait1 after lock", 32'(perf_wait1), 5);
`else
        checkOutput("perf_wait1 tied off", 32'(perf_wait1), 0);
`endif
        checkOutput("perf_wait0 after lock", 32'(perf_wait0), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = '0;
            r.v0 = ($urandom_range(0, 9) < 6);
            r.l0 = ($urandom_range(0, 3) == 0);
            r.c0 = codes[$urandom_range(0, 5)];
            r.a0 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
            r.b0 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
            r.v1 = ($urandom_range(0, 9) < 6);
            r.l1 = ($urandom_range(0, 3) == 0);
            r.c1 = codes[$urandom_range(0, 5)];
            r.a1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
            r.b1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
            applyStimulus(r);
        end
        applyStimulus('0);
        applyStimulus('0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter that shares the single-cycle 32-bit ALU between the main datapath (requester 0) and a secondary unit such as branch/address compare (requester 1). Each requester presents an operation with a valid/ready handshake. The block registers the winning operands into the ALU and returns the registered result and zero flag, with the owner's tag, two cycles after acceptance. Arbitration is round-robin, with an optional lock that holds the grant across back-to-back operations.

## Interface
- DATA_W, 32, operand/result width
- CTRL_W, 3, ALU control code width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  operation offered
- req0_ready / req1_ready  out  1  operation accepted this cycle (handshake = valid & ready)
- req0_lock / req1_lock  in  1  keep grant after this op
- req0_ctrl / req1_ctrl  in  CTRL_W  ALU code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
- req0_in1, req0_in2, req1_in1, req1_in2  in  DATA_W  operands
- alu_ctrl  out  CTRL_W  registered control to ALU
- alu_in1, alu_in2  out  DATA_W  registered operands to ALU
- alu_result  in  DATA_W  combinational ALU result
- alu_zero  in  1  ALU zero flag
- resp0_valid / resp1_valid  out  1  one-cycle result pulse to owner
- resp_result  out  DATA_W  registered result (shared bus)
- resp_zero  out  1  registered zero flag
- perf_wait0 / perf_wait1  out  16  stall counters (see Configuration)

## Operation
- FSM states: IDLE, OWN0, OWN1. OWNx means requester x holds a lock.
- IDLE: grant goes to the only valid requester. If both are valid, grant goes to the one not granted last (rr pointer). If neither is valid, there is no grant.
- OWNx: only requester x can be granted. The other requester's ready is 0 even if x is not valid.
- Transitions on a handshake by x: lock=1 → OWNx; lock=0 → IDLE.
- In OWNx with no handshake, the state is held.
- rr pointer updates to x on every handshake by x.
- reqx_ready = grant_x (combinational from state, rr pointer and valids). It has no dependency on resp state, because responses cannot be back-pressured.
- Stage 1, at the handshake edge: alu_ctrl/in1/in2 load the winner's fields; s1_valid=1; s1_owner=x.
- Stage 2, next edge: resp_result←alu_result, resp_zero←alu_zero, respX_valid←s1_valid & (s1_owner==X).
- Without a handshake, stage 1 holds its operands and clears s1_valid. alu_* outputs do not toggle when idle.
- Undefined ctrl codes are forwarded unchanged; the ALU returns 0, so resp_zero=1.

## Timing
- Acceptance at edge N → alu_* valid after N → respX_valid high for exactly one cycle after edge N+1.
- Latency 2 cycles. Throughput 1 op/cycle, including alternating owners.
- Reset values: all ready/resp_valid 0, alu_ctrl 000, alu_in1/in2 0, resp_result 0, resp_zero 0, state IDLE, rr pointer = 1 (requester 0 wins first tie), s1_valid 0, perf counters 0.
- Reset asserted mid-operation: in-flight stage-1/stage-2 ops are discarded and no response is issued. The first op after deassertion follows the IDLE rules.
- Lock and valid drop together in OWNx: the state stays OWNx until x performs a handshake with lock=0. There is no timeout.

## Configuration
- ALU_ARB_PERF_EN defined: perf_waitX increments each cycle with reqX_valid & !reqX_ready. Counters saturate at 16'hFFFF and are cleared only by reset.
- ALU_ARB_PERF_EN undefined: counter logic is absent and perf_wait0/1 are tied to 0. Ports are unchanged.

## Structure
- Shared package alu_pkg holds:
  - ALU control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT)
  - arbiter state encoding
  - DATA_W/CTRL_W defaults
- One sub-module: alu_arb_rr, the combinational grant logic (state, rr pointer, valids → grants). Pipeline registers, FSM and counters stay in the top.

## Test plan
- Single op: req0 ADD 5+7 → ready same cycle; resp0_valid 2 cycles later with result 12, zero 0; resp1_valid stays 0.
- Tie: both valid from reset, req0 SUB 9-9 and req1 OR 1|2. Required order:
  - req0 granted first, resp0 result 0, zero 1.
  - req1 granted next cycle, resp1 result 3.
  - Steady tie then alternates every cycle.
- Lock: req1 holds lock=1 for 3 ops (SLT 3<4, AND, ADD) with req0 valid throughout:
  - req0_ready stays 0 until req1 releases lock.
  - req0 is granted on the cycle after the unlocked op.
- Undefined code 011 on req0 → resp0 result 0, zero 1.
- Reset asserted one cycle after acceptance → no resp pulse; all outputs return to reset values.
- With ALU_ARB_PERF_EN: req1 blocked 5 cycles by req0's lock → perf_wait1=5, perf_wait0=0.
